// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial adder. One 1-bit full adder is reused LSB-first,
//               one bit per clock, to form {carry,sum} = a + b + cin.
//               Optional macro SERIAL_ADDER_OVF_EN adds a registered
//               two's-complement overflow flag (port ovf).
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             busy,
  output logic             done
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Counter must be at least one bit wide even when WIDTH == 1.
  localparam int              c_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_c;
  logic [c_CW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [WIDTH-1:0] w_res_next;
  logic             w_x;
  logic             w_y;
  logic             w_s;
  logic             w_co;
  logic             w_last;

  // Single full adder fed by the operand LSBs and the running carry.
  assign w_x    = r_a[0];
  assign w_y    = r_b[0];
  assign w_s    = w_x ^ w_y ^ r_c;
  assign w_co   = (w_x & w_y) | (w_x & r_c) | (w_y & r_c);
  assign w_last = (r_cnt == c_LAST);

  // Result bits enter at the MSB end so that after WIDTH shifts bit 0 of
  // the first computed bit lands at position 0. Only WIDTH-1 bits need to
  // be stored: the newest bit is always taken straight from the adder.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign w_res_next = w_s;
    end else begin : g_res_wn
      logic [WIDTH-2:0] r_res;

      assign w_res_next = {w_s, r_res};

      // Internal result shift register, advanced once per RUN cycle.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_res <= '0;
        end else if (r_state == S_RUN) begin
          r_res <= w_res_next[WIDTH-1:1];
        end
      end
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: start is only honoured in IDLE; DONE lasts one cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Operand capture, serial datapath and result publication.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a   <= a;
            r_b   <= b;
            r_c   <= cin;
            r_cnt <= '0;
          end
        end
        S_RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_c   <= w_co;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_sum   <= w_res_next;
            r_carry <= w_co;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic r_ovf;

  // On the last bit the adder inputs are the operand MSBs and w_s is the
  // result MSB, so overflow is decided from the adder itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if ((r_state == S_RUN) && w_last) begin
      r_ovf <= (w_x == w_y) && (w_s != w_x);
    end
  end

  assign ovf = r_ovf;
`endif

  assign sum   = r_sum;
  assign carry = r_carry;
  assign busy  = (r_state == S_RUN);
  assign done  = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Directed self-checking bench for serial_adder (WIDTH=8 and
//               WIDTH=1 instances). Honours SERIAL_ADDER_OVF_EN if defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic [7:0] sum;
  logic       carry;
  logic       busy;
  logic       done;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       cin1;
  logic [0:0] sum1;
  logic       carry1;
  logic       busy1;
  logic       done1;

`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf;
  logic       ovf1;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Bench-side copy of the last completed result, for stability checks.
  logic [7:0] last_sum;
  logic       last_carry;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sum   (sum),
    .carry (carry),
    .busy  (busy),
    .done  (done)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
    .sum   (sum1),
    .carry (carry1),
    .busy  (busy1),
    .done  (done1)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf1)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One WIDTH=8 addition from a start pulse to the idle cycle after done.
  // With disturb set, a second start with a changed operand is attempted
  // at E0+3 and must be ignored.
  task automatic add8(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                      input logic [7:0] es, input logic ec, input logic eo,
                      input bit disturb);
    @(negedge clk);
    a = va; b = vb; cin = vc; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~va; b = ~vb; cin = ~vc;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      check("run_busy", busy, 1'b1);
      check("run_done", done, 1'b0);
      check("run_sum_hold", sum, last_sum);
      check("run_carry_hold", carry, last_carry);
      if (disturb && i == 2) begin
        start = 1'b1; a = 8'hFF;
      end
      if (disturb && i == 3) start = 1'b0;
    end
    @(negedge clk);
    check("done_pulse", done, 1'b1);
    check("done_busy", busy, 1'b0);
    check("sum", sum, es);
    check("carry", carry, ec);
`ifdef SERIAL_ADDER_OVF_EN
    check("ovf", ovf, eo);
`else
    if (eo !== 1'b0 && eo !== 1'b1) check("ovf_arg", eo, 1'b0);
`endif
    last_sum = es; last_carry = ec;
    @(negedge clk);
    check("post_done", done, 1'b0);
    check("post_busy", busy, 1'b0);
    @(negedge clk);
    check("idle_busy", busy, 1'b0);
    check("idle_sum", sum, last_sum);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [1:0] fa [8];
    logic [2:0] v;
    int cyc;

    fa = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_sum", sum, 8'h00);
    check("rst_carry", carry, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sum_w1", sum1, 1'b0);
    check("rst_busy_w1", busy1, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf", ovf, 1'b0);
`endif
    last_sum = 8'h00; last_carry = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_nostart_busy", busy, 1'b0);
      check("idle_nostart_done", done, 1'b0);
    end

    // Directed additions.
    add8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    add8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    add8(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0);
    add8(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, 1'b1);
    add8(8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of an operation.
    @(negedge clk);
    a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_sum", sum, 8'h00);
    check("midrst_carry", carry, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    last_sum = 8'h00; last_carry = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("midrst_no_done", done, 1'b0);
      check("midrst_no_busy", busy, 1'b0);
    end
    add8(8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);

    // Back-to-back: start held high restarts every WIDTH+2 cycles.
    @(negedge clk);
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 20);
    check("b2b_first_done", done, 1'b1);
    check("b2b_first_latency", cyc, 9);
    check("b2b_first_sum", sum, 8'h03);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 30);
    check("b2b_second_done", done, 1'b1);
    check("b2b_period", cyc, 10);
    start = 1'b0;
    last_sum = 8'h03; last_carry = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    check("b2b_idle_busy", busy, 1'b0);
    check("b2b_idle_sum", sum, 8'h03);

    // WIDTH=1 full-adder truth table.
    for (int k = 0; k < 8; k++) begin
      v = k[2:0];
      @(negedge clk);
      a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      check("w1_busy", busy1, 1'b1);
      check("w1_done_early", done1, 1'b0);
      @(negedge clk);
      check("w1_done", done1, 1'b1);
      check("w1_busy_off", busy1, 1'b0);
      check("w1_result", {carry1, sum1}, fa[k]);
      @(negedge clk);
      check("w1_done_off", done1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
